doc_safety_payload_checker: RTL and testbench

// - Receiving end of the cross-comparison channel for safety payloads. It takes the local

---
 rtl/doc_safety_payload_checker.sv | 276 +++++++++++++++++++++++++++
 tb/tb_doc_safety_payload_checker.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/doc_safety_payload_checker.sv
// doc_safety_payload_checker
// Receiving end of the safety cross-comparison channel. It pairs the local payload
// with the redundant channel's payload, then checks sequence agreement, sequence
// increment, overspeed flag agreement and speed agreement within a margin. It drives a
// complementary pass pair and a latched fault code.
// Optional feature macro: DOC_SAFETY_CC_DEBOUNCE_EN. When defined, isolated speed-only
// disagreements are tolerated until P_DEBOUNCE_CNT of them occur back to back.
// When undefined, the first speed disagreement faults and there is no debounce counter.
module doc_safety_payload_checker #(
    parameter int P_SPEED_WIDTH    = 16,
    parameter int P_SEQ_WIDTH      = 8,
    parameter int P_CC_TIMEOUT_CYC = 100_000,
    parameter int P_DEBOUNCE_CNT   = 3
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            local_valid,
    input  logic signed [P_SPEED_WIDTH-1:0] local_speed,
    input  logic                            local_over_speed,
    input  logic        [P_SEQ_WIDTH-1:0]   local_seq,
    input  logic                            remote_valid,
    input  logic signed [P_SPEED_WIDTH-1:0] remote_speed,
    input  logic                            remote_over_speed,
    input  logic        [P_SEQ_WIDTH-1:0]   remote_seq,
    input  logic        [P_SPEED_WIDTH-1:0] speed_cc_margin,
    input  logic                            clear_fault,
    output logic                            cc_pass_p,
    output logic                            cc_pass_n,
    output logic                            cc_fault,
    output logic        [2:0]               fault_code,
    output logic                            compare_done
);

    // Timer only has to count up to P_CC_TIMEOUT_CYC-1.
    localparam int TMR_W = $clog2(P_CC_TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(P_CC_TIMEOUT_CYC - 1);

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_SPEED     = 3'd1;
    localparam logic [2:0] FC_OVERSPEED = 3'd2;
    localparam logic [2:0] FC_SEQ_DIFF  = 3'd3;
    localparam logic [2:0] FC_SEQ_STEP  = 3'd4;
    localparam logic [2:0] FC_TIMEOUT   = 3'd5;
    localparam logic [2:0] FC_DUPLICATE = 3'd6;

    // Reject parameter values that make the timeout or debounce threshold meaningless.
    if (P_CC_TIMEOUT_CYC < 2 || P_DEBOUNCE_CNT < 1) begin : g_param_check
        $error("doc_safety_payload_checker: P_CC_TIMEOUT_CYC must be >= 2 and P_DEBOUNCE_CNT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_COMPARE = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    state_t state;
    state_t nxt_state;

    // Captured payload fields (data path, not reset).
    logic signed [P_SPEED_WIDTH-1:0] loc_speed;
    logic signed [P_SPEED_WIDTH-1:0] rem_speed;
    logic                            loc_over_speed;
    logic                            rem_over_speed;
    logic        [P_SEQ_WIDTH-1:0]   loc_seq;
    logic        [P_SEQ_WIDTH-1:0]   rem_seq;
    logic        [P_SEQ_WIDTH-1:0]   prev_seq;

    // Control state.
    logic             side_local;   // in COLLECT: 1 = local arrived first
    logic [TMR_W-1:0] timer;
    logic             first_pair;

    // Compare results.
    logic [P_SEQ_WIDTH-1:0]   seq_expect;
    logic [P_SPEED_WIDTH:0]   speed_abs;
    logic                     speed_fail;
    logic [2:0]               cmp_code;
    logic                     cmp_fault;
    logic                     speed_soft;   // speed-only failure absorbed by debounce

    logic       same_again;
    logic       other_arrived;
    logic [2:0] fault_cause;

    logic       nxt_pass_p;
    logic       nxt_fault;
    logic [2:0] nxt_code;
    logic       nxt_done;

    // |a-b| computed one bit wider so full-scale opposite signs cannot overflow.
    function automatic logic [P_SPEED_WIDTH:0] speed_abs_diff(
        input logic signed [P_SPEED_WIDTH-1:0] a,
        input logic signed [P_SPEED_WIDTH-1:0] b
    );
        logic signed [P_SPEED_WIDTH:0] a_ext;
        logic signed [P_SPEED_WIDTH:0] b_ext;
        logic signed [P_SPEED_WIDTH:0] diff;
        a_ext = {a[P_SPEED_WIDTH-1], a};
        b_ext = {b[P_SPEED_WIDTH-1], b};
        diff  = a_ext - b_ext;
        return diff[P_SPEED_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    endfunction

    assign same_again    = side_local ? local_valid  : remote_valid;
    assign other_arrived = side_local ? remote_valid : local_valid;

    // Payload comparison in priority order: first failing check names the code.
    always_comb begin
        seq_expect = prev_seq + P_SEQ_WIDTH'(1);
        speed_abs  = speed_abs_diff(loc_speed, rem_speed);
        speed_fail = speed_abs > {1'b0, speed_cc_margin};
        cmp_code   = FC_NONE;
        if (loc_seq != rem_seq) begin
            cmp_code = FC_SEQ_DIFF;
        end else if (!first_pair && (loc_seq != seq_expect)) begin
            cmp_code = FC_SEQ_STEP;
        end else if (loc_over_speed != rem_over_speed) begin
            cmp_code = FC_OVERSPEED;
        end else if (speed_fail) begin
            cmp_code = FC_SPEED;
        end
    end

`ifdef DOC_SAFETY_CC_DEBOUNCE_EN
    localparam int DBC_W = $clog2(P_DEBOUNCE_CNT + 1);
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(P_DEBOUNCE_CNT - 1);

    logic [DBC_W-1:0] debounce_cnt;

    assign speed_soft = (cmp_code == FC_SPEED) && (debounce_cnt != DBC_LAST);

    // Count consecutive speed-only disagreements; any pass or fault clear restarts it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            debounce_cnt <= '0;
        end else if (state == S_COMPARE) begin
            if (cmp_code == FC_NONE) begin
                debounce_cnt <= '0;
            end else if (speed_soft) begin
                debounce_cnt <= debounce_cnt + DBC_W'(1);
            end
        end else if (state == S_FAULT && clear_fault) begin
            debounce_cnt <= '0;
        end
    end
`else
    assign speed_soft = 1'b0;
`endif

    assign cmp_fault = (cmp_code != FC_NONE) && !speed_soft;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // FSM next-state logic; also names the cause when heading into FAULT.
    always_comb begin
        nxt_state   = state;
        fault_cause = FC_NONE;
        unique case (state)
            S_IDLE: begin
                if (local_valid && remote_valid) begin
                    nxt_state = S_COMPARE;
                end else if (local_valid || remote_valid) begin
                    nxt_state = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (same_again) begin
                    nxt_state   = S_FAULT;
                    fault_cause = FC_DUPLICATE;
                end else if (other_arrived) begin
                    nxt_state = S_COMPARE;
                end else if (timer == TMR_LAST) begin
                    nxt_state   = S_FAULT;
                    fault_cause = FC_TIMEOUT;
                end
            end
            S_COMPARE: begin
                if (cmp_fault) begin
                    nxt_state   = S_FAULT;
                    fault_cause = cmp_code;
                end else begin
                    nxt_state = S_IDLE;
                end
            end
            S_FAULT: begin
                if (clear_fault) begin
                    nxt_state = S_IDLE;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered status outputs.
    always_comb begin
        nxt_pass_p = cc_pass_p;
        nxt_fault  = cc_fault;
        nxt_code   = fault_code;
        nxt_done   = (state == S_COMPARE);
        if (state != S_FAULT && nxt_state == S_FAULT) begin
            nxt_pass_p = 1'b0;
            nxt_fault  = 1'b1;
            nxt_code   = fault_cause;
        end else if (state == S_COMPARE && cmp_code == FC_NONE) begin
            nxt_pass_p = 1'b1;
        end else if (state == S_FAULT && clear_fault) begin
            nxt_fault = 1'b0;
            nxt_code  = FC_NONE;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cc_pass_p    <= 1'b0;
            cc_fault     <= 1'b0;
            fault_code   <= FC_NONE;
            compare_done <= 1'b0;
        end else begin
            cc_pass_p    <= nxt_pass_p;
            cc_fault     <= nxt_fault;
            fault_code   <= nxt_code;
            compare_done <= nxt_done;
        end
    end

    assign cc_pass_n = ~cc_pass_p;

    // Pairing control: which side arrived first, pair timer and first-pair flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            side_local <= 1'b0;
            timer      <= '0;
            first_pair <= 1'b1;
        end else begin
            if (state == S_IDLE && (local_valid ^ remote_valid)) begin
                side_local <= local_valid;
                timer      <= '0;
            end else if (state == S_COLLECT) begin
                timer <= timer + TMR_W'(1);
            end
            if (state == S_COMPARE && cmp_code == FC_NONE) begin
                first_pair <= 1'b0;
            end else if (state == S_FAULT && clear_fault) begin
                first_pair <= 1'b1;
            end
        end
    end

    // Payload capture and previous sequence count.
    always_ff @(posedge clk) begin
        if (local_valid && (state == S_IDLE || (state == S_COLLECT && !side_local))) begin
            loc_speed      <= local_speed;
            loc_over_speed <= local_over_speed;
            loc_seq        <= local_seq;
        end
        if (remote_valid && (state == S_IDLE || (state == S_COLLECT && side_local))) begin
            rem_speed      <= remote_speed;
            rem_over_speed <= remote_over_speed;
            rem_seq        <= remote_seq;
        end
        if (state == S_COMPARE && (cmp_code == FC_NONE || speed_soft)) begin
            prev_seq <= loc_seq;
        end
    end

endmodule

// File: tb/tb_doc_safety_payload_checker.sv
// Testbench for doc_safety_payload_checker: table of single-pair vectors, hand-written
// multi-cycle sequences (timeout, duplicate, reset mid-pair, debounce) and randomized
// pairs checked against a transaction-level reference model.
module tb_doc_safety_payload_checker;

    localparam int SW   = 16;
    localparam int QW   = 8;
    localparam int P_TO = 40;
    localparam int P_DB = 3;
`ifdef DOC_SAFETY_CC_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 local_valid;
    logic signed [SW-1:0] local_speed;
    logic                 local_over_speed;
    logic        [QW-1:0] local_seq;
    logic                 remote_valid;
    logic signed [SW-1:0] remote_speed;
    logic                 remote_over_speed;
    logic        [QW-1:0] remote_seq;
    logic        [SW-1:0] speed_cc_margin;
    logic                 clear_fault;
    logic                 cc_pass_p;
    logic                 cc_pass_n;
    logic                 cc_fault;
    logic        [2:0]    fault_code;
    logic                 compare_done;

    always #5 clk = ~clk;

    doc_safety_payload_checker #(
        .P_SPEED_WIDTH   (SW),
        .P_SEQ_WIDTH     (QW),
        .P_CC_TIMEOUT_CYC(P_TO),
        .P_DEBOUNCE_CNT  (P_DB)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .local_valid      (local_valid),
        .local_speed      (local_speed),
        .local_over_speed (local_over_speed),
        .local_seq        (local_seq),
        .remote_valid     (remote_valid),
        .remote_speed     (remote_speed),
        .remote_over_speed(remote_over_speed),
        .remote_seq       (remote_seq),
        .speed_cc_margin  (speed_cc_margin),
        .clear_fault      (clear_fault),
        .cc_pass_p        (cc_pass_p),
        .cc_pass_n        (cc_pass_n),
        .cc_fault         (cc_fault),
        .fault_code       (fault_code),
        .compare_done     (compare_done)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state (transaction level).
    bit m_first;
    int m_prev;
    bit m_pass;
    int m_dbc;

    typedef struct {
        bit prime_en;
        int prime_seq;
        int lseq;
        int rseq;
        bit los;
        bit ros;
        int lspd;
        int rspd;
        int margin;
        int code;
    } vec_t;

    vec_t tbl[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        local_valid  = 1'b0;
        remote_valid = 1'b0;
        clear_fault  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        m_first = 1'b1;
        m_pass  = 1'b0;
        m_dbc   = 0;
        m_prev  = 0;
    endtask

    // order 0: both valids together; 1: local first; 2: remote first (gap idle cycles between).
    task automatic do_pair(input int ls, input int rs, input bit los, input bit ros,
                           input int lsp, input int rsp, input int order, input int gap);
        local_seq         = QW'(ls);
        remote_seq        = QW'(rs);
        local_over_speed  = los;
        remote_over_speed = ros;
        local_speed       = SW'(lsp);
        remote_speed      = SW'(rsp);
        if (order == 0) begin
            local_valid  = 1'b1;
            remote_valid = 1'b1;
            tick();
            local_valid  = 1'b0;
            remote_valid = 1'b0;
        end else begin
            if (order == 1) local_valid = 1'b1;
            else            remote_valid = 1'b1;
            tick();
            local_valid  = 1'b0;
            remote_valid = 1'b0;
            repeat (gap) tick();
            if (order == 1) remote_valid = 1'b1;
            else            local_valid = 1'b1;
            tick();
            local_valid  = 1'b0;
            remote_valid = 1'b0;
        end
        chk("done_before_compare", int'(compare_done), 0);
        tick();
        chk("compare_done", int'(compare_done), 1);
    endtask

    task automatic clear_and_check();
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("clear_fault_flag", int'(cc_fault), 0);
        chk("clear_fault_code", int'(fault_code), 0);
        chk("clear_pass_p", int'(cc_pass_p), 0);
        m_first = 1'b1;
        m_dbc   = 0;
    endtask

    // Expected compare outcome from the payload rules, in plain integer arithmetic.
    function automatic int ref_code(input int ls, input int rs, input bit los, input bit ros,
                                    input int lsp, input int rsp, input int margin);
        int d;
        if (ls != rs) return 3;
        if (!m_first && ls != (m_prev + 1) % 256) return 4;
        if (los != ros) return 2;
        d = lsp - rsp;
        if (d < 0) d = -d;
        if (d > margin) return 1;
        return 0;
    endfunction

    task automatic check_pair(input int ls, input int rs, input bit los, input bit ros,
                              input int lsp, input int rsp, input int margin,
                              input int order, input int gap);
        int code;
        int exp_code;
        bit f;
        code            = ref_code(ls, rs, los, ros, lsp, rsp, margin);
        speed_cc_margin = SW'(margin);
        do_pair(ls, rs, los, ros, lsp, rsp, order, gap);
        f        = 1'b0;
        exp_code = 0;
        if (code == 0) begin
            m_prev  = ls;
            m_first = 1'b0;
            m_pass  = 1'b1;
            m_dbc   = 0;
        end else if (code == 1 && DB_EN) begin
            m_dbc++;
            if (m_dbc >= P_DB) begin
                f        = 1'b1;
                exp_code = 1;
                m_pass   = 1'b0;
            end else begin
                m_prev = ls;
            end
        end else begin
            f        = 1'b1;
            exp_code = code;
            m_pass   = 1'b0;
        end
        chk("rnd_fault", int'(cc_fault), int'(f));
        chk("rnd_code", int'(fault_code), exp_code);
        chk("rnd_pass_p", int'(cc_pass_p), int'(m_pass));
        chk("rnd_pass_n", int'(cc_pass_n), int'(!m_pass));
        if (f) clear_and_check();
    endtask

    // Global bound on run time.
    initial begin
        #500_000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ls, rs, lsp, rsp, margin;
        bit los, ros;

        local_valid       = 1'b0;
        remote_valid      = 1'b0;
        clear_fault       = 1'b0;
        local_speed       = '0;
        remote_speed      = '0;
        local_seq         = '0;
        remote_seq        = '0;
        local_over_speed  = 1'b0;
        remote_over_speed = 1'b0;
        speed_cc_margin   = SW'(130);

        // prime_en, prime_seq, lseq, rseq, los, ros, lspd, rspd, margin, code
        tbl[0]  = '{1'b1, 0,   1, 1, 1'b0, 1'b0, 1000,   1040,   130,   0};
        tbl[1]  = '{1'b0, 0,   0, 0, 1'b0, 1'b0, 1000,   1130,   130,   0};
        tbl[2]  = '{1'b0, 0,   0, 0, 1'b0, 1'b0, 1000,   1131,   130,   1};
        tbl[3]  = '{1'b0, 0,   2, 2, 1'b0, 1'b0, -32768, 32767,  130,   1};
        tbl[4]  = '{1'b1, 255, 0, 0, 1'b0, 1'b0, 1000,   1000,   130,   0};
        tbl[5]  = '{1'b1, 7,   9, 9, 1'b0, 1'b0, 1000,   1000,   130,   4};
        tbl[6]  = '{1'b0, 0,   4, 5, 1'b0, 1'b0, 1000,   1000,   130,   3};
        tbl[7]  = '{1'b1, 3,   4, 4, 1'b1, 1'b0, 1000,   1000,   130,   2};
        tbl[8]  = '{1'b0, 0,   6, 6, 1'b0, 1'b0, 1131,   1000,   130,   1};
        tbl[9]  = '{1'b0, 0,   6, 6, 1'b1, 1'b1, 1130,   1000,   130,   0};
        tbl[10] = '{1'b0, 0,   6, 6, 1'b0, 1'b0, -5,     -5,     0,     0};
        tbl[11] = '{1'b0, 0,   6, 6, 1'b0, 1'b0, -32768, 32767,  65535, 0};
        tbl[12] = '{1'b0, 0,   4, 5, 1'b1, 1'b0, 1000,   1000,   130,   3};
        tbl[13] = '{1'b1, 7,   9, 9, 1'b1, 1'b0, 0,      5000,   130,   4};
        tbl[14] = '{1'b0, 0,   6, 6, 1'b0, 1'b0, 32767,  -32768, 65534, 1};

        // Reset values.
        do_reset();
        reset_n = 1'b0;
        chk("reset_pass_p", int'(cc_pass_p), 0);
        chk("reset_pass_n", int'(cc_pass_n), 1);
        chk("reset_fault", int'(cc_fault), 0);
        chk("reset_code", int'(fault_code), 0);
        chk("reset_done", int'(compare_done), 0);
        reset_n = 1'b1;

        // Table-driven single pairs, each from a fresh reset.
        for (int i = 0; i < 15; i++) begin
            int ec;
            int ef;
            int ep;
            do_reset();
            speed_cc_margin = SW'(tbl[i].margin);
            if (tbl[i].prime_en) begin
                do_pair(tbl[i].prime_seq, tbl[i].prime_seq, 1'b0, 1'b0, 500, 500, 0, 0);
                chk("tbl_prime_pass", int'(cc_pass_p), 1);
            end
            do_pair(tbl[i].lseq, tbl[i].rseq, tbl[i].los, tbl[i].ros,
                    tbl[i].lspd, tbl[i].rspd, i % 3, i % 4);
            ec = tbl[i].code;
            ef = (ec != 0) ? 1 : 0;
            ep = (ec == 0) ? 1 : 0;
            if (DB_EN && ec == 1) begin
                ec = 0;
                ef = 0;
                ep = int'(tbl[i].prime_en);
            end
            chk("tbl_code", int'(fault_code), ec);
            chk("tbl_fault", int'(cc_fault), ef);
            chk("tbl_pass_p", int'(cc_pass_p), ep);
            chk("tbl_pass_n", int'(cc_pass_n), 1 - ep);
            tick();
            chk("tbl_done_fall", int'(compare_done), 0);
        end

        // Pairs seq 0..3 with local leading by two cycles.
        do_reset();
        speed_cc_margin = SW'(130);
        for (int s = 0; s < 4; s++) begin
            do_pair(s, s, 1'b0, 1'b0, 1000, 1040, 1, 2);
            chk("seq_run_pass_p", int'(cc_pass_p), 1);
            chk("seq_run_fault", int'(cc_fault), 0);
        end
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("clear_outside_fault_pass", int'(cc_pass_p), 1);

        // Timeout: local seq 5, remote only after the timeout window.
        do_reset();
        local_seq   = QW'(5);
        local_valid = 1'b1;
        tick();
        local_valid = 1'b0;
        repeat (P_TO - 1) tick();
        chk("pre_timeout_fault", int'(cc_fault), 0);
        tick();
        chk("timeout_fault", int'(cc_fault), 1);
        chk("timeout_code", int'(fault_code), 5);
        chk("timeout_pass_p", int'(cc_pass_p), 0);
        chk("timeout_pass_n", int'(cc_pass_n), 1);
        remote_seq   = QW'(5);
        remote_valid = 1'b1;
        tick();
        remote_valid = 1'b0;
        tick();
        chk("fault_ignores_valid_done", int'(compare_done), 0);
        tick();
        chk("fault_ignores_valid_done2", int'(compare_done), 0);
        chk("timeout_code_held", int'(fault_code), 5);

        // Duplicate local valid, then clear with a simultaneous (ignored) pair.
        do_reset();
        local_seq   = QW'(10);
        local_valid = 1'b1;
        tick();
        tick();
        local_valid = 1'b0;
        chk("dup_fault", int'(cc_fault), 1);
        chk("dup_code", int'(fault_code), 6);
        clear_fault  = 1'b1;
        local_valid  = 1'b1;
        remote_valid = 1'b1;
        tick();
        clear_fault  = 1'b0;
        local_valid  = 1'b0;
        remote_valid = 1'b0;
        chk("dup_clear_code", int'(fault_code), 0);
        chk("dup_clear_fault", int'(cc_fault), 0);
        chk("dup_clear_pass_p", int'(cc_pass_p), 0);
        tick();
        tick();
        chk("clear_valid_ignored", int'(compare_done), 0);
        do_pair(77, 77, 1'b0, 1'b0, 1000, 1000, 0, 0);
        chk("first_pair_after_clear", int'(cc_pass_p), 1);
        chk("first_pair_after_clear_code", int'(fault_code), 0);

        // Duplicate remote valid arriving together with the local one.
        do_reset();
        remote_valid = 1'b1;
        tick();
        local_valid = 1'b1;
        tick();
        local_valid  = 1'b0;
        remote_valid = 1'b0;
        chk("dup_remote_code", int'(fault_code), 6);

        // Reset while collecting discards the half pair.
        do_reset();
        do_pair(1, 1, 1'b0, 1'b0, 1000, 1000, 0, 0);
        chk("pre_collect_pass", int'(cc_pass_p), 1);
        local_valid = 1'b1;
        tick();
        local_valid = 1'b0;
        reset_n     = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("collect_rst_pass_p", int'(cc_pass_p), 0);
        chk("collect_rst_pass_n", int'(cc_pass_n), 1);
        chk("collect_rst_fault", int'(cc_fault), 0);
        chk("collect_rst_code", int'(fault_code), 0);
        chk("collect_rst_done", int'(compare_done), 0);
        remote_valid = 1'b1;
        tick();
        remote_valid = 1'b0;
        tick();
        chk("collect_rst_no_compare", int'(compare_done), 0);
        tick();
        chk("collect_rst_no_compare2", int'(compare_done), 0);

`ifdef DOC_SAFETY_CC_DEBOUNCE_EN
        // Three consecutive speed-only failures: fault only on the third.
        do_reset();
        speed_cc_margin = SW'(130);
        for (int s = 0; s < 3; s++) begin
            do_pair(s, s, 1'b0, 1'b0, 1000, 1131, 0, 0);
            chk("debounce_fault", int'(cc_fault), (s == 2) ? 1 : 0);
            chk("debounce_code", int'(fault_code), (s == 2) ? 1 : 0);
        end
`endif

        // Randomized pairs against the reference model.
        do_reset();
        for (int n = 0; n < 250; n++) begin
            margin = int'($urandom_range(0, 300));
            if (m_first) begin
                ls = int'($urandom_range(0, 255));
            end else if ($urandom_range(0, 9) < 8) begin
                ls = (m_prev + 1) % 256;
            end else begin
                ls = int'($urandom_range(0, 255));
            end
            rs  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : ls;
            los = 1'($urandom_range(0, 1));
            ros = ($urandom_range(0, 7) == 0) ? !los : los;
            lsp = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 7) == 0) begin
                rsp = int'($urandom_range(0, 65535)) - 32768;
            end else begin
                rsp = lsp + int'($urandom_range(0, 2 * margin + 20)) - margin - 10;
                if (rsp > 32767)  rsp = 32767;
                if (rsp < -32768) rsp = -32768;
            end
            check_pair(ls, rs, los, ros, lsp, rsp, margin,
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 5)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
